// File: rtl/lcd_rgb_pkg.sv
// Shared definitions for the DE-mode LCD RGB receiver: FSM encoding,
// coordinate widths and panel geometry (full panel and reduced simulation panel).
package lcd_rgb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_FRAME  = 2'd2
    } rx_state_t;

    localparam int X_W         = 10;
    localparam int Y_W         = 9;
    localparam int FRAME_CNT_W = 12;

    localparam int LCD_H_ACTIVE = 480;
    localparam int LCD_V_ACTIVE = 272;
    localparam int LCD_H_BLANK  = 45;
    localparam int LCD_V_BLANK  = 18;

    localparam int SIM_H_ACTIVE = 64;
    localparam int SIM_V_ACTIVE = 32;
    localparam int SIM_H_BLANK  = 5;
    localparam int SIM_V_BLANK  = 3;

endpackage

// File: rtl/lcd_bus_sync.sv
// Brings the asynchronous LCD bus into the clk domain: two flop stages for
// every bus bit, a third for dclk, and a rising-edge detect on dclk.
module lcd_bus_sync (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dclk_in,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [23:0] rgb_in,
    output logic        sample_edge,
    output logic        de_sync,
    output logic        hsync_sync,
    output logic        vsync_sync,
    output logic [23:0] rgb_sync
);

    logic [27:0] stage1;
    logic [27:0] stage2;
    logic        dclk_stage3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage1      <= '0;
            stage2      <= '0;
            dclk_stage3 <= 1'b0;
        end else begin
            stage1      <= {dclk_in, de_in, hsync_in, vsync_in, rgb_in};
            stage2      <= stage1;
            dclk_stage3 <= stage2[27];
        end
    end

    // The source holds data well before dclk rises, so stage2 data is stable here.
    assign sample_edge = stage2[27] & ~dclk_stage3;
    assign de_sync     = stage2[26];
    assign hsync_sync  = stage2[25];
    assign vsync_sync  = stage2[24];
    assign rgb_sync    = stage2[23:0];

endmodule

// File: rtl/lcd_rgb_rx.sv
// DE-mode LCD RGB receiver: frames pixels into x/y coordinates with lock and
// dclk-loss detection. Define LCD_RGB_RX_CHECK_EN to enable the geometry checker.
module lcd_rgb_rx
    import lcd_rgb_pkg::*;
#(
    parameter int H_ACTIVE     = LCD_H_ACTIVE,
    parameter int V_ACTIVE     = LCD_V_ACTIVE,
    parameter int DCLK_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dclk_in,
    input  logic                   de_in,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic [7:0]             red_in,
    input  logic [7:0]             green_in,
    input  logic [7:0]             blue_in,
    output logic                   pix_valid,
    output logic [X_W-1:0]         pix_x,
    output logic [Y_W-1:0]         pix_y,
    output logic [23:0]            pix_rgb,
    output logic                   frame_start,
    output logic                   line_end,
    output logic                   locked,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   err_width,
    output logic                   err_height
);

    localparam int TO_W = $clog2(DCLK_TIMEOUT + 1);

    logic        sample;
    logic        de_s;
    logic        hsync_s;
    logic        vsync_s;
    logic [23:0] rgb_s;

    lcd_bus_sync u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .dclk_in     (dclk_in),
        .de_in       (de_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .rgb_in      ({red_in, green_in, blue_in}),
        .sample_edge (sample),
        .de_sync     (de_s),
        .hsync_sync  (hsync_s),
        .vsync_sync  (vsync_s),
        .rgb_sync    (rgb_s)
    );

    // DE mode carries all timing on de/vsync; hsync is synchronised but not needed.
    logic unused_hsync;
    assign unused_hsync = hsync_s;

    rx_state_t        state;
    rx_state_t        state_next;
    logic [TO_W-1:0]  to_cnt;
    logic             timeout;
    logic             prev_de;
    logic [X_W-1:0]   x_cnt;
    logic [Y_W-1:0]   y_cnt;
    logic             frame_begin;
    logic             frame_end;
    logic             pixel_hit;
    logic             line_hit;
    logic             lock_kill;

    assign timeout = !sample && (to_cnt == TO_W'(DCLK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (sample || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        frame_begin = 1'b0;
        frame_end   = 1'b0;
        pixel_hit   = 1'b0;
        line_hit    = 1'b0;
        if (timeout) begin
            state_next = ST_IDLE;
        end else if (sample) begin
            case (state)
                ST_IDLE: begin
                    if (!vsync_s) state_next = ST_VBLANK;
                end
                ST_VBLANK: begin
                    if (vsync_s) begin
                        state_next  = ST_FRAME;
                        frame_begin = 1'b1;
                    end
                end
                ST_FRAME: begin
                    pixel_hit = de_s;
                    line_hit  = prev_de && !de_s;
                    if (!vsync_s) begin
                        state_next = ST_VBLANK;
                        frame_end  = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_count <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            prev_de     <= 1'b0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            if (sample) prev_de <= de_s;
            if (timeout) begin
                x_cnt   <= '0;
                y_cnt   <= '0;
                pix_x   <= '0;
                pix_y   <= '0;
                prev_de <= 1'b0;
            end
            if (frame_begin) begin
                frame_start <= 1'b1;
                frame_count <= frame_count + 1'b1;
                x_cnt       <= '0;
                y_cnt       <= '0;
            end
            if (pixel_hit) begin
                pix_valid <= 1'b1;
                pix_rgb   <= rgb_s;
                pix_x     <= x_cnt;
                pix_y     <= y_cnt;
                x_cnt     <= (x_cnt == '1) ? x_cnt : x_cnt + 1'b1;
            end
            if (line_hit) begin
                line_end <= 1'b1;
                x_cnt    <= '0;
                y_cnt    <= (y_cnt == '1) ? y_cnt : y_cnt + 1'b1;
            end
        end
    end

`ifdef LCD_RGB_RX_CHECK_EN
    logic width_bad;
    logic height_bad;

    // x_cnt/y_cnt hold the number of pixels/lines seen when the line or frame closes.
    assign width_bad  = line_hit && (x_cnt != X_W'(H_ACTIVE));
    assign height_bad = frame_end && (y_cnt != Y_W'(V_ACTIVE));
    assign lock_kill  = err_width || err_height || width_bad || height_bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_width  <= 1'b0;
            err_height <= 1'b0;
        end else begin
            if (width_bad)  err_width  <= 1'b1;
            if (height_bad) err_height <= 1'b1;
        end
    end
`else
    localparam int unused_geometry = H_ACTIVE + V_ACTIVE;
    assign lock_kill  = 1'b0;
    assign err_width  = 1'b0;
    assign err_height = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            locked <= 1'b0;
        end else if (timeout || lock_kill) begin
            locked <= 1'b0;
        end else if (frame_end) begin
            locked <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Directed bench for lcd_rgb_rx: drives a 69x35 DE-mode bus at clk/10 with a
// 64x32 active window and checks framing, lock, timeout and reset behaviour.
module tb_lcd_rgb_rx;
    import lcd_rgb_pkg::*;

    localparam int H_TOT = SIM_H_ACTIVE + SIM_H_BLANK;

    logic                   clk;
    logic                   rst_n;
    logic                   dclk_in;
    logic                   de_in;
    logic                   hsync_in;
    logic                   vsync_in;
    logic [7:0]             red_in;
    logic [7:0]             green_in;
    logic [7:0]             blue_in;
    logic                   pix_valid;
    logic [X_W-1:0]         pix_x;
    logic [Y_W-1:0]         pix_y;
    logic [23:0]            pix_rgb;
    logic                   frame_start;
    logic                   line_end;
    logic                   locked;
    logic [FRAME_CNT_W-1:0] frame_count;
    logic                   err_width;
    logic                   err_height;

    int vec_cnt = 0;
    int err_cnt = 0;
    int pv_cnt  = 0;
    int le_cnt  = 0;
    int fs_cnt  = 0;
    int last_x  = -1;
    int last_y  = -1;
    int pv_snap, le_snap, fs_snap;
    int pv_evt, le_evt;

    lcd_rgb_rx #(
        .H_ACTIVE     (SIM_H_ACTIVE),
        .V_ACTIVE     (SIM_V_ACTIVE),
        .DCLK_TIMEOUT (1024)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dclk_in     (dclk_in),
        .de_in       (de_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .red_in      (red_in),
        .green_in    (green_in),
        .blue_in     (blue_in),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .frame_start (frame_start),
        .line_end    (line_end),
        .locked      (locked),
        .frame_count (frame_count),
        .err_width   (err_width),
        .err_height  (err_height)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pix_model(input int x, input int y);
        if (x == 10 && y == 5) return 24'h123456;
        return {8'(x), 8'(y), 8'(x + 3 * y)};
    endfunction

    // Every delivered pixel must carry the colour the source drove at its coordinates.
    always @(negedge clk) begin
        if (pix_valid) begin
            pv_cnt++;
            last_x = int'(pix_x);
            last_y = int'(pix_y);
            check_output("pix_rgb_vs_xy", 32'(pix_rgb), 32'(pix_model(int'(pix_x), int'(pix_y))));
        end
        if (line_end)    le_cnt++;
        if (frame_start) fs_cnt++;
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic drive_cycle(input logic de, input logic vs, input logic [23:0] rgb, input bit probe);
        @(negedge clk);
        dclk_in  = 1'b0;
        de_in    = de;
        vsync_in = vs;
        hsync_in = ~de;
        {red_in, green_in, blue_in} = rgb;
        repeat (4) @(negedge clk);
        @(negedge clk);
        dclk_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (probe && i == 2) check_output("probe_early", 32'(pix_valid), 32'd0);
            if (probe && i == 3) begin
                check_output("probe_valid", 32'(pix_valid), 32'd1);
                check_output("probe_x", 32'(pix_x), 32'd10);
                check_output("probe_y", 32'(pix_y), 32'd5);
                check_output("probe_rgb", 32'(pix_rgb), 32'h123456);
            end
        end
    endtask

    task automatic do_stall();
        le_evt = le_cnt;
        repeat (1100) @(negedge clk);
        check_output("stall_locked", 32'(locked), 32'd0);
        check_output("stall_state_idle", 32'(dut.state), 32'(ST_IDLE));
        check_output("stall_no_line_end", 32'(le_cnt - le_evt), 32'd0);
        pv_evt = pv_cnt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_output("rst_pix_valid", 32'(pix_valid), 32'd0);
        check_output("rst_frame_start", 32'(frame_start), 32'd0);
        check_output("rst_line_end", 32'(line_end), 32'd0);
        check_output("rst_locked", 32'(locked), 32'd0);
        check_output("rst_err_width", 32'(err_width), 32'd0);
        check_output("rst_err_height", 32'(err_height), 32'd0);
        check_output("rst_pix_x", 32'(pix_x), 32'd0);
        check_output("rst_pix_y", 32'(pix_y), 32'd0);
        check_output("rst_pix_rgb", 32'(pix_rgb), 32'd0);
        check_output("rst_frame_count", 32'(frame_count), 32'd0);
        pv_evt = pv_cnt;
    endtask

    task automatic drive_line(input int y, input logic vs, input int n_de, input bit probe,
                              input int stop_x, input int rst_x);
        for (int x = 0; x < H_TOT; x++) begin
            drive_cycle(x < n_de, vs, (x < n_de) ? pix_model(x, y) : 24'h0,
                        probe && (x == 10) && (y == 5));
            if (x == stop_x) do_stall();
            if (x == rst_x)  do_reset();
        end
    endtask

    // One back-porch line with vsync high, the active lines, then two vsync-low lines.
    task automatic apply_stimulus(input int n_lines, input int short_y, input bit probe,
                                  input int stop_y, input int stop_x, input int rst_y, input int rst_x);
        drive_line(0, 1'b1, 0, 1'b0, -1, -1);
        for (int y = 0; y < n_lines; y++) begin
            drive_line(y, 1'b1, (y == short_y) ? SIM_H_ACTIVE - 1 : SIM_H_ACTIVE, probe,
                       (y == stop_y) ? stop_x : -1, (y == rst_y) ? rst_x : -1);
            if (y == short_y) begin
                check_output("short_err_width", 32'(err_width), 32'd1);
                check_output("short_locked", 32'(locked), 32'd0);
            end
            if (y == stop_y || y == rst_y) break;
        end
        drive_line(0, 1'b0, 0, 1'b0, -1, -1);
        drive_line(0, 1'b0, 0, 1'b0, -1, -1);
    endtask

    task automatic snap();
        pv_snap = pv_cnt;
        le_snap = le_cnt;
        fs_snap = fs_cnt;
    endtask

    task automatic check_clean_frame(input int exp_fc, input int exp_lock);
        check_output("frame_pix_count", 32'(pv_cnt - pv_snap), 32'd2048);
        check_output("frame_line_ends", 32'(le_cnt - le_snap), 32'd32);
        check_output("frame_starts", 32'(fs_cnt - fs_snap), 32'd1);
        check_output("frame_last_x", 32'(last_x), 32'd63);
        check_output("frame_last_y", 32'(last_y), 32'd31);
        check_output("frame_count", 32'(frame_count), 32'(exp_fc));
        check_output("frame_locked", 32'(locked), 32'(exp_lock));
        check_output("frame_err_height", 32'(err_height), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        dclk_in  = 1'b0;
        de_in    = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        red_in   = 8'h00;
        green_in = 8'h00;
        blue_in  = 8'h00;
        repeat (3) @(negedge clk);
        check_output("reset_pix_valid", 32'(pix_valid), 32'd0);
        check_output("reset_locked", 32'(locked), 32'd0);
        check_output("reset_frame_count", 32'(frame_count), 32'd0);
        check_output("reset_pix_xy_rgb", {pix_rgb[7:0], 5'd0, pix_y, pix_x}, 32'd0);
        check_output("reset_errors", {30'd0, err_width, err_height}, 32'd0);
        check_output("reset_state_idle", 32'(dut.state), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // de active while vsync is low: nothing may come out outside a frame.
        drive_line(0, 1'b0, SIM_H_ACTIVE, 1'b0, -1, -1);
        check_output("blank_no_pix", 32'(pv_cnt), 32'd0);
        check_output("blank_no_line_end", 32'(le_cnt), 32'd0);
        check_output("blank_no_frame_start", 32'(fs_cnt), 32'd0);

        snap();
        apply_stimulus(SIM_V_ACTIVE, -1, 1'b1, -1, -1, -1, -1);
        check_clean_frame(1, 1);
        check_output("f1_err_width", 32'(err_width), 32'd0);

`ifdef LCD_RGB_RX_CHECK_EN
        snap();
        apply_stimulus(SIM_V_ACTIVE, 7, 1'b0, -1, -1, -1, -1);
        check_output("bad_pix_count", 32'(pv_cnt - pv_snap), 32'd2047);
        check_output("bad_frame_count", 32'(frame_count), 32'd2);
        check_output("bad_locked", 32'(locked), 32'd0);
        check_output("bad_err_height", 32'(err_height), 32'd0);
        snap();
        apply_stimulus(SIM_V_ACTIVE, -1, 1'b0, -1, -1, -1, -1);
        check_clean_frame(3, 0);
        check_output("after_bad_err_width", 32'(err_width), 32'd1);
`else
        snap();
        apply_stimulus(SIM_V_ACTIVE, -1, 1'b0, -1, -1, -1, -1);
        check_clean_frame(2, 1);
        check_output("f2_err_width", 32'(err_width), 32'd0);
`endif

        // dclk stops mid line 1; the rest of that frame must be ignored.
        snap();
        apply_stimulus(SIM_V_ACTIVE, -1, 1'b0, 1, 20, -1, -1);
        check_output("restart_no_pix", 32'(pv_cnt - pv_evt), 32'd0);
        check_output("restart_no_line_end", 32'(le_cnt - le_evt), 32'd0);
        check_output("restart_locked", 32'(locked), 32'd0);
        check_output("restart_state_vblank", 32'(dut.state), 32'(ST_VBLANK));

        // Reset pulse at line 12, then a short frame to show recovery.
        apply_stimulus(SIM_V_ACTIVE, -1, 1'b0, -1, -1, 12, 20);
        check_output("post_reset_no_pix", 32'(pv_cnt - pv_evt), 32'd0);
        snap();
        apply_stimulus(2, -1, 1'b0, -1, -1, -1, -1);
        check_output("resume_frame_starts", 32'(fs_cnt - fs_snap), 32'd1);
        check_output("resume_frame_count", 32'(frame_count), 32'd1);
        check_output("resume_pix_count", 32'(pv_cnt - pv_snap), 32'd128);
        check_output("resume_last_x", 32'(last_x), 32'd63);
        check_output("resume_last_y", 32'(last_y), 32'd1);
        check_output("resume_err_width", 32'(err_width), 32'd0);
`ifdef LCD_RGB_RX_CHECK_EN
        check_output("resume_err_height", 32'(err_height), 32'd1);
        check_output("resume_locked", 32'(locked), 32'd0);
`else
        check_output("resume_err_height", 32'(err_height), 32'd0);
        check_output("resume_locked", 32'(locked), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/lcd_rgb_rx.md
LCD_RGB_RX -- requirements
Module: lcd_rgb_rx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 480, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 272, active lines per frame.
REQ-003 SHALL have parameter DCLK_TIMEOUT, default 1024, clk cycles without dclk rising edge before loss of lock.
REQ-004 SHALL have ports: clk input 1 system clock; rst_n input 1 synchronous active-low reset.
REQ-005 SHALL have ports: dclk_in, de_in, hsync_in, vsync_in input 1 each, DE-mode LCD bus (asynchronous to clk).
REQ-006 SHALL have ports: red_in, green_in, blue_in input 8 each, pixel data.
REQ-007 SHALL have ports: pix_valid output 1; pix_x output 10; pix_y output 9; pix_rgb output 24 {red,green,blue}.
REQ-008 SHALL have ports: frame_start output 1, line_end output 1, locked output 1, frame_count output 12.
REQ-009 SHALL have ports: err_width output 1, err_height output 1 (sticky).

Function
REQ-010 SHALL pass all bus inputs through two clk flop stages; dclk through a third; sample edge = stage2 dclk high and stage3 dclk low.
REQ-011 SHALL sample stage2 de/vsync/rgb only on sample edge (source holds data >=4 clk before dclk rise).
REQ-012 SHALL implement FSM IDLE, VBLANK, FRAME; IDLE->VBLANK on sampled vsync=0; VBLANK->FRAME on sampled vsync=1; FRAME->VBLANK on sampled vsync=0.
REQ-013 SHALL pulse frame_start one clk on VBLANK->FRAME transition; frame_count increments same cycle, wraps 4095->0.
REQ-014 In FRAME, each sample with de=1 SHALL produce pix_valid one clk pulse, 1 clk after sample edge, with pix_rgb, pix_x, pix_y.
REQ-015 pix_x SHALL start 0 per line, increment per valid pixel; saturate at 1023.
REQ-016 Sample de 1->0 SHALL pulse line_end one clk, clear x, increment y; y saturates at 511, cleared on frame_start.
REQ-017 No pix_valid in IDLE or VBLANK regardless of de.
REQ-018 locked SHALL set at first FRAME->VBLANK after frame_start was seen; cleared by timeout or reset.
REQ-019 If DCLK_TIMEOUT consecutive clk cycles pass without sample edge, FSM SHALL go to IDLE, locked=0, x/y=0; counter restarts on every sample edge.
REQ-020 Timeout mid-line SHALL not emit line_end.

Reset
REQ-021 On rst_n=0 at clk edge: FSM IDLE; pix_valid, frame_start, line_end, locked, err_width, err_height = 0; pix_x, pix_y, pix_rgb, frame_count = 0; sync flops and timeout counter = 0.
REQ-022 Reset mid-frame SHALL require a fresh VBLANK before any pix_valid.

Configuration
REQ-023 Macro LCD_RGB_RX_CHECK_EN defined: at line_end, pix_x count != H_ACTIVE sets err_width; at FRAME->VBLANK, line count != V_ACTIVE sets err_height; any error also clears locked and blocks setting it until reset.
REQ-024 Macro undefined: err_width, err_height tied 0; locked per REQ-018 only; no checker logic.

Structure
REQ-025 Shared package lcd_rgb_pkg SHALL hold FSM state encoding, coordinate widths (10/9), and geometry constants (480x272, blanking 45/18; SIM 64x32, blanking 5/3).
REQ-026 Sub-module lcd_bus_sync (2/3-stage synchronizer + dclk edge detect) SHALL be separate; all else in lcd_rgb_rx.

Verification
REQ-027 Bench SHALL drive bus model: dclk=clk/10, data change on dclk fall, geometry 69x35 total, 64x32 active, blanking 5/3.
REQ-028 Scenario: two clean frames, H_ACTIVE=64, V_ACTIVE=32 -> 2048 pix_valid per frame, last pix_x=63 pix_y=31, 32 line_end, frame_count=2, locked=1 after first frame, errors 0.
REQ-029 Scenario: pixel (x=10,y=5) rgb=0x12_34_56 -> pix_valid with pix_x=10, pix_y=5, pix_rgb=0x123456, 1 clk after sample edge.
REQ-030 Scenario (CHECK_EN): line 7 has 63 de pixels -> err_width=1 at that line_end, locked=0, stays 0 through next good frame.
REQ-031 Scenario: stop dclk mid-line for 1100 clk -> locked=0, state IDLE, no line_end; restart -> pix_valid only after next VBLANK->FRAME.
REQ-032 Scenario: rst_n low 1 clk at y=12 -> all outputs 0; resumes pix_valid after next frame_start, frame_count=1.
